mul_unit: RTL

MUL_UNIT -- requirements
Module: mul_unit

---
 rtl/mul_unit.sv | 100 ++++++++++
 1 files changed

// File: rtl/mul_unit.sv
// mul_unit: 32x32 unsigned shift-add multiplier with HI/LO result registers.
// Ports: clk, rst_n (async, active-low), Src1/Src2 operands, funct select,
//        dataOut (HI/LO readout), busy (operation in flight), done (1-cycle pulse).
module mul_unit #(
   parameter logic [5:0] FN_MULTU = 6'b011001,
   parameter logic [5:0] FN_MFHI  = 6'b010000,
   parameter logic [5:0] FN_MFLO  = 6'b010001
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] Src1,
   input  logic [31:0] Src2,
   input  logic [5:0]  funct,
   output logic [31:0] dataOut,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_n;
   logic [31:0] mcand;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [64:0] prod;
   logic [4:0]  cnt;
   logic [32:0] sum;
   logic        start;

   // Starts are only honoured from IDLE, so a MULTU while busy is dropped.
   assign start = (state == IDLE) && (funct == FN_MULTU);

   // Upper half plus multiplicand, carry kept in bit 32.
   assign sum = {1'b0, prod[63:32]} + {1'b0, mcand};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      busy    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_n = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == 5'd31) state_n = FIN;
         end
         FIN: begin
            busy    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand <= '0;
         prod  <= '0;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         done  <= 1'b0;
      end else begin
         done <= (state == FIN);
         if (start) begin
            mcand <= Src1;
            prod  <= {33'b0, Src2};
            cnt   <= '0;
         end else if (state == RUN) begin
            // Add-then-shift folded into one assignment.
            if (prod[0]) prod <= {1'b0, sum, prod[31:1]};
            else         prod <= {1'b0, prod[64:1]};
            cnt <= cnt + 5'd1;
         end else if (state == FIN) begin
            hi <= prod[63:32];
            lo <= prod[31:0];
         end
      end
   end

   always_comb begin
      dataOut = 32'h0;
      if (funct == FN_MFHI)      dataOut = hi;
      else if (funct == FN_MFLO) dataOut = lo;
   end

endmodule
